// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_ctrl
// Brief    : Register-programmed scan controller for an 8-digit multiplexed
//            seven-segment display. Per-digit hex/dp/blank registers, a
//            brightness register and an enable bit are written over a simple
//            MMIO-style port. Anodes are sequenced with a fixed dwell per
//            slot, a dead time at the end of each slot and PWM brightness
//            gating. an/sseg are active-low and driven straight from flops.
// Revision : 1.0  initial release
// ============================================================================
module sseg_scan_ctrl #(
  parameter int TICK_DIV  = 6250,  // cycles per digit slot, including dead time
  parameter int BLANK_CYC = 64,    // dead cycles at the end of each slot
  parameter int PWM_W     = 4      // brightness register width
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  // Dwell counter must hold the longest phase and also supply PWM_W bits of
  // PWM phase, so it is sized to whichever is wider.
  localparam int c_cnt_raw_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_cnt_w     = (c_cnt_raw_w > PWM_W) ? c_cnt_raw_w : PWM_W;

  localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(TICK_DIV - BLANK_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYC - 1);

  localparam logic [3:0] c_addr_bright = 4'd8;
  localparam logic [3:0] c_addr_ctrl   = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [5:0]       r_digit [8];   // [5] blank, [4] dp, [3:0] hex
  logic [PWM_W-1:0] r_bright;
  logic             r_enable;
  logic [7:0]       r_rd_data;
  logic [7:0]       w_rd_data;

  // Data bits beyond what any register stores are deliberately dropped.
  logic w_unused_data;
  assign w_unused_data = ^wr_data[7:6];

  // Register writes: one per strobe, unknown addresses are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_digit[i] <= '0;
      end
      r_bright <= '1;
      r_enable <= 1'b0;
    end else if (wr_en) begin
      if (!wr_addr[3]) begin
        r_digit[wr_addr[2:0]] <= wr_data[5:0];
      end else if (wr_addr == c_addr_bright) begin
        r_bright <= wr_data[PWM_W-1:0];
      end else if (wr_addr == c_addr_ctrl) begin
        r_enable <= wr_data[0];
      end
    end
  end

  // Readback mux; bits not stored and unmapped addresses read as zero.
  always_comb begin
    w_rd_data = 8'h00;
    if (!rd_addr[3]) begin
      w_rd_data = {2'b00, r_digit[rd_addr[2:0]]};
    end else if (rd_addr == c_addr_bright) begin
      w_rd_data = 8'(r_bright);
    end else if (rd_addr == c_addr_ctrl) begin
      w_rd_data = {7'b0000000, r_enable};
    end
  end

  // Registered readback; sampling pre-edge values means a same-cycle write
  // returns the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= w_rd_data;
    end
  end

  assign rd_data = r_rd_data;

  // --------------------------------------------------------------------------
  // Scan sequencer
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;

  // Sequencer state, dwell counter, digit index and wrap marker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Next-state logic: slot timing depends only on the counter, never on data.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_wrap_nxt  = 1'b0;
    if (!r_enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SHOW;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
        end
        S_SHOW: begin
          if (r_cnt == c_show_last) begin
            w_state_nxt = S_BLANK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_BLANK: begin
          if (r_cnt == c_blank_last) begin
            w_state_nxt = S_SHOW;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 3'd1;
            // Marks the hop from digit 7 back to digit 0 so the frame pulse
            // can line up with the first pins of the new frame.
            w_wrap_nxt  = (r_idx == 3'd7);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pin generation
  // --------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [5:0]       w_cur_digit;
  logic [PWM_W-1:0] w_pwm_cnt;
  logic             w_lit;
  logic [7:0]       w_an_nxt;
  logic [7:0]       w_sseg_nxt;

  // Pin values for the next edge. Enable is folded in so a disable darkens
  // the pins one edge after the write, without waiting for the state to move.
  always_comb begin
    w_cur_digit = r_digit[r_idx];
    w_pwm_cnt   = r_cnt[PWM_W-1:0];
    w_lit       = (r_state == S_SHOW) && r_enable &&
                  (w_pwm_cnt <= r_bright) && !w_cur_digit[5];
    w_an_nxt    = 8'hFF;
    w_sseg_nxt  = 8'hFF;
    if (w_lit) begin
      w_an_nxt   = ~(8'h01 << r_idx);
      w_sseg_nxt = {~w_cur_digit[4], hex_to_seg(w_cur_digit[3:0])};
    end
  end

  logic [7:0] r_an;
  logic [7:0] r_sseg;
  logic       r_frame_tick;

  // Output flops: pins and frame pulse are glitch-free and one cycle behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an         <= 8'hFF;
      r_sseg       <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_sseg       <= w_sseg_nxt;
      r_frame_tick <= r_wrap & r_enable;
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_ctrl
// Brief    : Directed self-checking bench for sseg_scan_ctrl with a short
//            slot (16 cycles, 2 dead) so full frames are 128 cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_sseg_scan_ctrl;

  localparam int TICK_DIV  = 16;
  localparam int BLANK_CYC = 2;
  localparam int PWM_W     = 4;
  localparam int c_show    = TICK_DIV - BLANK_CYC;
  localparam int c_frame   = 8 * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  sseg_scan_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC),
    .PWM_W     (PWM_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  // 100 MHz bench clock.
  always #5 clk = ~clk;

  int cyc = 0;
  // Free-running cycle count used to place every sample on the slot schedule.
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected register contents and the cycle count at which enable rose.
  logic [5:0] m_dig [8];
  logic [3:0] m_bright;
  logic       m_en;
  int         t_en;
  // Hand-decoded segment bytes for the digit values written below.
  logic [7:0] seg_tab [8];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pins first show slot 0 two edges after the enable write edge.
  function automatic int offs();
    return cyc - t_en - 2;
  endfunction

  function automatic logic [7:0] exp_an();
    int o, slot, ph;
    o = offs();
    if (!m_en || o < 0) return 8'hFF;
    slot = (o / TICK_DIV) % 8;
    ph   = o % TICK_DIV;
    if (ph < c_show && ph <= int'(m_bright) && !m_dig[slot][5])
      return ~(8'h01 << slot);
    return 8'hFF;
  endfunction

  function automatic logic [7:0] exp_sseg();
    int o;
    o = offs();
    if (exp_an() == 8'hFF) return 8'hFF;
    return seg_tab[(o / TICK_DIV) % 8];
  endfunction

  function automatic logic exp_tick();
    int o;
    o = offs();
    return m_en && (o > 0) && (o % c_frame == 0);
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("an", an, exp_an());
      check("sseg", sseg, exp_sseg());
      check("frame_tick", {7'd0, frame_tick}, {7'd0, exp_tick()});
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    if (a < 4'd8) m_dig[a[2:0]] = d[5:0];
    else if (a == 4'd8) m_bright = d[3:0];
    else if (a == 4'd9) begin
      if (!m_en && d[0]) t_en = cyc;
      m_en = d[0];
    end
  endtask

  task automatic read(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    check(tag, rd_data, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = 6'd0;
    m_bright = 4'hF;
    m_en     = 1'b0;
  endtask

  initial begin
    int k;
    seg_tab[0] = 8'h92;  // 0x05 : '5', dp off
    seg_tab[1] = 8'h08;  // 0x1A : 'A', dp lit
    seg_tab[2] = 8'hB0;  // 0x03 : '3', dp off
    seg_tab[3] = 8'h0E;  // 0x1F : 'F', dp lit
    seg_tab[4] = 8'hC6;  // 0x0C : 'C', dp off
    seg_tab[5] = 8'hA1;  // 0x0D : 'd', dp off
    seg_tab[6] = 8'h78;  // 0x17 : '7', dp lit
    seg_tab[7] = 8'h83;  // 0x0B : 'b', dp off
    model_reset();
    t_en    = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = 8'd0;
    rd_addr = 4'd0;
    repeat (3) tick();
    check("rst_an", an, 8'hFF);
    check("rst_sseg", sseg, 8'hFF);
    check("rst_rd", rd_data, 8'h00);
    reset = 1'b0;

    // Idle after reset: dark, no frame pulses, reset register values.
    read("rd_ctrl_rst", 4'd9, 8'h00);
    read("rd_bright_rst", 4'd8, 8'h0F);
    read("rd_d0_rst", 4'd0, 8'h00);
    run(40);

    // Program digits; upper data bits on d0 are not stored.
    write(4'd0, 8'hC5);
    write(4'd1, 8'h1A);
    write(4'd2, 8'h03);
    rd_addr = 4'd3;
    write(4'd3, 8'h1F);
    check("rd_same_cycle_old", rd_data, 8'h00);
    tick();
    check("rd_same_cycle_new", rd_data, 8'h1F);
    write(4'd4, 8'h0C);
    write(4'd5, 8'h0D);
    write(4'd6, 8'h17);
    write(4'd7, 8'h0B);
    read("rd_d0_masked", 4'd0, 8'h05);
    read("rd_d1", 4'd1, 8'h1A);

    // Enable and scan several full frames at full brightness.
    write(4'd9, 8'h01);
    run(3 * c_frame + 4);

    // Brightness gating: 4 of 16 phases, then 1, then full.
    write(4'd8, 8'h03);
    run(c_frame);
    write(4'd8, 8'h00);
    run(c_frame / 2);
    write(4'd8, 8'hFF);
    read("rd_bright_masked", 4'd8, 8'h0F);
    run(c_frame / 4);

    // Blank digit 2: its slot stays dark, later slots keep their schedule.
    write(4'd2, 8'h23);
    run(c_frame + 8);
    read("rd_d2_blank", 4'd2, 8'h23);
    write(4'd12, 8'hFF);
    read("rd_unmapped", 4'd12, 8'h00);
    read("rd_ctrl_on", 4'd9, 8'h01);

    // Walk to the middle of slot 5, then disable.
    k = 0;
    while ((offs() % c_frame) != (5 * TICK_DIV + 6) && k < 300) begin
      run(1);
      k++;
    end
    check("slot5_reached", {7'd0, (k < 300)}, 8'h01);
    write(4'd9, 8'h00);
    run(24);

    // Re-enable: scan restarts from digit 0.
    write(4'd9, 8'h01);
    run(c_frame + 20);

    // Asynchronous reset in the middle of a slot.
    #3;
    reset = 1'b1;
    #1;
    check("arst_an", an, 8'hFF);
    check("arst_sseg", sseg, 8'hFF);
    check("arst_tick", {7'd0, frame_tick}, 8'h00);
    check("arst_rd", rd_data, 8'h00);
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    read("rd_d0_after_rst", 4'd0, 8'h00);
    read("rd_bright_after_rst", 4'd8, 8'h0F);
    read("rd_ctrl_after_rst", 4'd9, 8'h00);
    run(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
